// File: rtl/game_pkg.sv
// Purpose: shared constants, collision-nibble bit indices and detector FSM encoding.
// Latency: n/a (declarations and a pure helper only).
// Backpressure: n/a.
package game_pkg;

    // Board and tank geometry, in pixels
    localparam int BOARD_W_PX  = 640;
    localparam int BOARD_H_PX  = 480;
    localparam int TANK_HALF_W = 8;
    localparam int TANK_H      = 8;

    // Samples after arm rise during which the shooter's own tank is masked
    localparam int GRACE = 4;

    // Projectile position is 10.8 fixed point
    localparam int FRAC  = 8;
    localparam int POS_W = 18;
    localparam int PX_W  = 10;

    // Collision nibble bit positions
    localparam int CLIDE_TANK0   = 3;
    localparam int CLIDE_TANK1   = 2;
    localparam int CLIDE_TERRAIN = 1;
    localparam int CLIDE_CLEAR   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_EVAL = 2'd3
    } det_state_t;

    // Integer pixel part of a fixed-point coordinate (fraction is truncated)
    function automatic logic [PX_W-1:0] to_px(input logic [POS_W-1:0] pos);
        return pos[POS_W-1:FRAC];
    endfunction

endpackage

// File: rtl/hitbox_check.sv
// Purpose: tests whether a pixel lies inside one tank's rectangular hit box.
// Latency: combinational.
// Backpressure: none.
//
// Ports: px/py = projectile pixel; tank_x/tank_y = tank base centre; hit = inside box.
// Box spans x in [tank_x-HALF_W, tank_x+HALF_W] and y in [tank_y-HEIGHT, tank_y].
module hitbox_check
    import game_pkg::*;
#(
    parameter int HALF_W = TANK_HALF_W,
    parameter int HEIGHT = TANK_H
) (
    input  logic [PX_W-1:0] px,
    input  logic [PX_W-1:0] py,
    input  logic [PX_W-1:0] tank_x,
    input  logic [PX_W-1:0] tank_y,
    output logic            hit
);

    localparam logic [PX_W:0] HW_E = (PX_W+1)'(HALF_W);
    localparam logic [PX_W:0] H_E  = (PX_W+1)'(HEIGHT);

    logic [PX_W:0] px_e;
    logic [PX_W:0] py_e;
    logic [PX_W:0] tx_e;
    logic [PX_W:0] ty_e;
    logic [PX_W:0] x_lo;
    logic [PX_W:0] x_hi;
    logic [PX_W:0] y_lo;

    // One extra bit so tank_x + HALF_W cannot wrap; lower bounds clamp at 0
    always_comb begin
        px_e = {1'b0, px};
        py_e = {1'b0, py};
        tx_e = {1'b0, tank_x};
        ty_e = {1'b0, tank_y};
        x_lo = (tx_e >= HW_E) ? (tx_e - HW_E) : '0;
        x_hi = tx_e + HW_E;
        y_lo = (ty_e >= H_E) ? (ty_e - H_E) : '0;
        hit  = (px_e >= x_lo) && (px_e <= x_hi) && (py_e >= y_lo) && (py_e <= ty_e);
    end

endmodule

// File: rtl/impact_detector.sv
// Purpose: samples the projectile position and classifies it against terrain and both tanks.
// Latency: sample_req at cycle N -> result_valid pulse and new clide_state at N+3.
// Backpressure: sample_req is dropped while busy or while arm is low; nothing is queued.
//
// Ports:
//   clock_50m, rst            clock, synchronous active-high reset
//   arm, shooter              projectile in flight; which tank fired (0/1)
//   sample_req, pos_x, pos_y  evaluate request and 10.8 fixed-point position
//   tankN_x, tankN_y          tank base centres in pixels
//   terrain_addr/height       external ROM, 1-cycle read latency
//   busy, result_valid        evaluation in progress; one-cycle result strobe
//   clide_state               {tank0 hit, tank1 hit, terrain hit, clear}
module impact_detector
    import game_pkg::*;
#(
    parameter int BOARD_W_PX  = game_pkg::BOARD_W_PX,
    parameter int BOARD_H_PX  = game_pkg::BOARD_H_PX,
    parameter int TANK_HALF_W = game_pkg::TANK_HALF_W,
    parameter int TANK_H      = game_pkg::TANK_H,
    parameter int GRACE       = game_pkg::GRACE
) (
    input  logic             clock_50m,
    input  logic             rst,
    input  logic             arm,
    input  logic             shooter,
    input  logic             sample_req,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    input  logic [PX_W-1:0]  tank0_x,
    input  logic [PX_W-1:0]  tank0_y,
    input  logic [PX_W-1:0]  tank1_x,
    input  logic [PX_W-1:0]  tank1_y,
    output logic [7:0]       terrain_addr,
    input  logic [PX_W-1:0]  terrain_height,
    output logic             busy,
    output logic             result_valid,
    output logic [3:0]       clide_state
);

    localparam int GW = $clog2(GRACE + 1);

    det_state_t     state;
    logic           arm_q;
    logic [GW-1:0]  grace_cnt;
    logic           shooter_q;
    logic [PX_W-1:0] px_q;
    logic [PX_W-1:0] py_q;
    logic [PX_W-1:0] t0x_q;
    logic [PX_W-1:0] t0y_q;
    logic [PX_W-1:0] t1x_q;
    logic [PX_W-1:0] t1y_q;

    logic [PX_W-1:0] px_in;
    logic [PX_W-1:0] py_in;
    logic            hit0;
    logic            hit1;
    logic            in_board;
    logic            terr_hit;
    logic            grace_on;
    logic            t0_hit;
    logic            t1_hit;
    logic [3:0]      clide_nxt;

    assign px_in = to_px(pos_x);
    assign py_in = to_px(pos_y);

    hitbox_check #(.HALF_W(TANK_HALF_W), .HEIGHT(TANK_H)) u_hit0 (
        .px     (px_q),
        .py     (py_q),
        .tank_x (t0x_q),
        .tank_y (t0y_q),
        .hit    (hit0)
    );

    hitbox_check #(.HALF_W(TANK_HALF_W), .HEIGHT(TANK_H)) u_hit1 (
        .px     (px_q),
        .py     (py_q),
        .tank_x (t1x_q),
        .tank_y (t1y_q),
        .hit    (hit1)
    );

    // Result is formed in WAIT, where terrain_height is the ROM word for the
    // latched column, so it is registered straight into clide_state.
    always_comb begin
        in_board = ({1'b0, px_q} < (PX_W+1)'(BOARD_W_PX)) &&
                   ({1'b0, py_q} < (PX_W+1)'(BOARD_H_PX));
        terr_hit = ({1'b0, py_q} >= {1'b0, terrain_height});
        grace_on = (grace_cnt < GW'(GRACE));
        // Shell leaving the barrel overlaps its own tank for the first samples
        t0_hit   = hit0 && !(grace_on && !shooter_q);
        t1_hit   = hit1 && !(grace_on &&  shooter_q);
        clide_nxt = '0;
        if (in_board) begin
            clide_nxt[CLIDE_TANK0]   = t0_hit;
            clide_nxt[CLIDE_TANK1]   = t1_hit;
            clide_nxt[CLIDE_TERRAIN] = terr_hit;
            clide_nxt[CLIDE_CLEAR]   = !(t0_hit || t1_hit || terr_hit);
        end
    end

    always_ff @(posedge clock_50m) begin
        if (rst) begin
            state        <= ST_IDLE;
            arm_q        <= 1'b0;
            grace_cnt    <= '0;
            shooter_q    <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            t0x_q        <= '0;
            t0y_q        <= '0;
            t1x_q        <= '0;
            t1y_q        <= '0;
            terrain_addr <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            clide_state  <= 4'b0001;
        end else begin
            arm_q        <= arm;
            result_valid <= 1'b0;
            if (!arm) begin
                // Projectile gone: abandon any evaluation, no strobe
                state       <= ST_IDLE;
                busy        <= 1'b0;
                clide_state <= 4'b0001;
            end else begin
                if (!arm_q) begin
                    grace_cnt <= '0;
                end else if (state == ST_WAIT && grace_cnt < GW'(GRACE)) begin
                    grace_cnt <= grace_cnt + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (sample_req) begin
                            px_q         <= px_in;
                            py_q         <= py_in;
                            t0x_q        <= tank0_x;
                            t0y_q        <= tank0_y;
                            t1x_q        <= tank1_x;
                            t1y_q        <= tank1_y;
                            shooter_q    <= shooter;
                            // Address goes out with the latch so the ROM reads during ADDR
                            terrain_addr <= px_in[PX_W-1:2];
                            busy         <= 1'b1;
                            state        <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        clide_state  <= clide_nxt;
                        result_valid <= 1'b1;
                        state        <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_impact_detector.sv
module tb_impact_detector;

    logic        clock_50m = 1'b0;
    logic        rst;
    logic        arm;
    logic        shooter;
    logic        sample_req;
    logic [17:0] pos_x;
    logic [17:0] pos_y;
    logic [9:0]  tank0_x;
    logic [9:0]  tank0_y;
    logic [9:0]  tank1_x;
    logic [9:0]  tank1_y;
    logic [7:0]  terrain_addr;
    logic [9:0]  terrain_height;
    logic        busy;
    logic        result_valid;
    logic [3:0]  clide_state;

    int tests  = 0;
    int failed = 0;
    int pulse_cnt = 0;

    logic [9:0] rom [256];

    impact_detector dut (
        .clock_50m      (clock_50m),
        .rst            (rst),
        .arm            (arm),
        .shooter        (shooter),
        .sample_req     (sample_req),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .tank0_x        (tank0_x),
        .tank0_y        (tank0_y),
        .tank1_x        (tank1_x),
        .tank1_y        (tank1_y),
        .terrain_addr   (terrain_addr),
        .terrain_height (terrain_height),
        .busy           (busy),
        .result_valid   (result_valid),
        .clide_state    (clide_state)
    );

    always #10 clock_50m = ~clock_50m;

    // Height-map ROM, one cycle read latency
    always @(posedge clock_50m) terrain_height <= rom[terrain_addr];

    always @(negedge clock_50m) if (result_valid === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_50m);
        #1;
    endtask

    // Strobe one request in cycle N; returns in cycle N+1
    task automatic req(input logic [17:0] x, input logic [17:0] y);
        pos_x = x;
        pos_y = y;
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 10'd450;
        rom[25]  = 10'd300;
        rom[101] = 10'd300;
        terrain_height = '0;
        rst = 1'b1; arm = 1'b0; shooter = 1'b0; sample_req = 1'b0;
        pos_x = '0; pos_y = '0;
        tank0_x = 10'd500; tank0_y = 10'd400;
        tank1_x = 10'd600; tank1_y = 10'd400;

        // 1: reset
        step(); step();
        check("rst_clide", clide_state, 4'b0001);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_addr", terrain_addr, 0);
        rst = 1'b0;
        arm = 1'b1;
        step();

        // 2: in board, above terrain, no tanks
        req(18'h06400, 18'h03200);
        check("t2_busy_n1", busy, 1);
        check("t2_addr", terrain_addr, 25);
        check("t2_rv_n1", result_valid, 0);
        step();
        check("t2_rv_n2", result_valid, 0);
        step();
        check("t2_rv_n3", result_valid, 1);
        check("t2_clide", clide_state, 4'b0001);
        check("t2_busy_n3", busy, 1);
        step();
        check("t2_rv_n4", result_valid, 0);
        check("t2_busy_n4", busy, 0);

        // 3: below terrain, second strobe while busy is dropped
        pulse_cnt = 0;
        req(18'h06400, 18'h13600);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        step();
        check("t3_clide", clide_state, 4'b0010);
        check("t3_rv", result_valid, 1);
        step(); step(); step();
        check("t3_pulses", pulse_cnt, 1);
        check("t3_busy_after", busy, 0);

        // 4: hit on tank1 (not the shooter)
        shooter = 1'b0;
        tank0_x = 10'd100; tank0_y = 10'd100;
        tank1_x = 10'd400; tank1_y = 10'd300;
        req(18'h19500, 18'h12700);
        check("t4_addr", terrain_addr, 101);
        step(); step();
        check("t4_clide", clide_state, 4'b0100);
        check("t4_rv", result_valid, 1);
        step();

        // 5: grace window on shooter's own tank
        tank0_x = 10'd100; tank0_y = 10'd200;
        tank1_x = 10'd600; tank1_y = 10'd400;
        arm = 1'b0;
        step();
        check("t5_armlow_clide", clide_state, 4'b0001);
        req(18'h06400, 18'h0C600);
        check("t5_armlow_busy", busy, 0);
        step(); step();
        check("t5_armlow_rv", result_valid, 0);
        arm = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            req(18'h06400, 18'h0C600);
            step(); step();
            check($sformatf("t5_grace%0d", i), clide_state, (i < 4) ? 32'h1 : 32'h8);
            check($sformatf("t5_rv%0d", i), result_valid, 1);
            step();
        end

        // 6: out of board, then abort by dropping arm
        req(18'h2BC00, 18'h03200);
        check("t6_addr", terrain_addr, 175);
        step(); step();
        check("t6_clide", clide_state, 4'b0000);
        check("t6_rv", result_valid, 1);
        step();
        pulse_cnt = 0;
        req(18'h06400, 18'h03200);
        step();
        arm = 1'b0;
        step();
        check("t6_abort_rv", result_valid, 0);
        check("t6_abort_clide", clide_state, 4'b0001);
        check("t6_abort_busy", busy, 0);
        step(); step();
        check("t6_abort_pulses", pulse_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
